// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard unit: forward selects and memory-wait FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

  // E-stage operand source selects
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Memory-wait tracker states
  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear (clear wins over increment).
// Latency: count visible the cycle after the increment.
// Backpressure: none; holds at all-ones once saturated.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Next count: clear, else increment unless already at all-ones
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: forwarding, load-use/branch stalls, multi-cycle memory and mult/div tracking.
// Latency: all stall/flush/forward outputs are combinational from inputs and current state.
// Backpressure: memwait freezes F/D/E/M and bubbles W; other hazards freeze F/D and bubble E.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MEM_LAT = 1,
  parameter int MD_LAT  = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              BranchD,
  input  logic              MfhiloD,
  input  logic              StartMDD,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              MemAccessM,
  input  logic              StartMDE,
  input  logic              CntClear,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushE,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic              MdBusy,
  output logic [CNT_W-1:0]  LoadStallCnt,
  output logic [CNT_W-1:0]  BranchStallCnt,
  output logic [CNT_W-1:0]  MemStallCnt,
  output logic [CNT_W-1:0]  MdStallCnt
);

  // A single-cycle memory never waits; otherwise the first cycle plus MEM_LAT-2 counted cycles stall
  localparam bit         MEM_MULTI  = (MEM_LAT > 1);
  localparam logic [3:0] MEM_RELOAD = MEM_MULTI ? 4'(MEM_LAT - 2) : 4'd0;
  localparam logic [6:0] MD_RELOAD  = 7'(MD_LAT);

  mem_state_e mem_state_q, mem_state_d;
  logic [3:0] mem_cnt_q, mem_cnt_d;
  logic [6:0] md_cnt_q, md_cnt_d;
  logic       memwait;
  logic       lwstall;
  logic       brstall;
  logic       mdstall;

  // Operand forwarding: M result has priority over W; register 0 never forwards
  always_comb begin
    ForwardAE = FWD_RF;
    if ((RsE != '0) && (RsE == WriteRegM) && RegWriteM) begin
      ForwardAE = FWD_M;
    end else if ((RsE != '0) && (RsE == WriteRegW) && RegWriteW) begin
      ForwardAE = FWD_W;
    end
    ForwardBE = FWD_RF;
    if ((RtE != '0) && (RtE == WriteRegM) && RegWriteM) begin
      ForwardBE = FWD_M;
    end else if ((RtE != '0) && (RtE == WriteRegW) && RegWriteW) begin
      ForwardBE = FWD_W;
    end
  end

  assign ForwardAD = (RsD != '0) && (RsD == WriteRegM) && RegWriteM;
  assign ForwardBD = (RtD != '0) && (RtD == WriteRegM) && RegWriteM;

  // Load-use compares against the load's destination, which is what actually gets written
  assign lwstall = MemtoRegE && (WriteRegE != '0) &&
                   ((RsD == WriteRegE) || (RtD == WriteRegE));

  assign brstall = BranchD &&
                   ((RegWriteE && (WriteRegE != '0) &&
                     ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                    (MemtoRegM && (WriteRegM != '0) &&
                     ((WriteRegM == RsD) || (WriteRegM == RtD))));

  // Memory wait next-state; the exit cycle ignores MemAccessM so a back-to-back access starts from IDLE
  always_comb begin
    mem_state_d = mem_state_q;
    mem_cnt_d   = mem_cnt_q;
    memwait     = 1'b0;
    case (mem_state_q)
      MEM_IDLE: begin
        if (MemAccessM && MEM_MULTI) begin
          memwait     = 1'b1;
          mem_cnt_d   = MEM_RELOAD;
          mem_state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        memwait = (mem_cnt_q != 4'd0);
        if (mem_cnt_q != 4'd0) begin
          mem_cnt_d = mem_cnt_q - 4'd1;
        end else begin
          mem_state_d = MEM_IDLE;
        end
      end
    endcase
  end

  // Mult/div busy countdown; a start held in a frozen E is only accepted once M moves
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (StartMDE && !memwait) begin
      md_cnt_d = MD_RELOAD;
    end else if (md_cnt_q != 7'd0) begin
      md_cnt_d = md_cnt_q - 7'd1;
    end
  end

  // Tracker state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_state_q <= MEM_IDLE;
      mem_cnt_q   <= 4'd0;
      md_cnt_q    <= 7'd0;
    end else begin
      mem_state_q <= mem_state_d;
      mem_cnt_q   <= mem_cnt_d;
      md_cnt_q    <= md_cnt_d;
    end
  end

  assign MdBusy  = (md_cnt_q != 7'd0);
  assign mdstall = (MdBusy || StartMDE) && (MfhiloD || StartMDD);

  assign StallF = memwait || lwstall || brstall || mdstall;
  assign StallD = StallF;
  assign StallE = memwait;
  assign StallM = memwait;
  assign FlushW = memwait;
  // E is frozen during memwait, so it must not also be bubbled
  assign FlushE = (lwstall || brstall || mdstall) && !memwait;

  sat_counter #(.W(CNT_W)) u_load_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (CntClear),
    .inc   (lwstall && !memwait),
    .q     (LoadStallCnt)
  );

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (CntClear),
    .inc   (brstall && !memwait),
    .q     (BranchStallCnt)
  );

  sat_counter #(.W(CNT_W)) u_mem_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (CntClear),
    .inc   (memwait),
    .q     (MemStallCnt)
  );

  sat_counter #(.W(CNT_W)) u_md_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (CntClear),
    .inc   (mdstall && !memwait),
    .q     (MdStallCnt)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus randomized traffic against a behavioural model.
// Latency: outputs sampled mid-cycle; model state advances on each rising edge.
// Backpressure: n/a.
module tb_hazard_scoreboard;

  localparam int REG_AW  = 5;
  localparam int MEM_LAT = 3;
  localparam int MD_LAT  = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [REG_AW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic BranchD, MfhiloD, StartMDD, RegWriteE, RegWriteM, RegWriteW;
  logic MemtoRegE, MemtoRegM, MemAccessM, StartMDE, CntClear;
  logic StallF, StallD, StallE, StallM, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic ForwardAD, ForwardBD, MdBusy;
  logic [CNT_W-1:0] LoadStallCnt, BranchStallCnt, MemStallCnt, MdStallCnt;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .REG_AW (REG_AW),
    .MEM_LAT(MEM_LAT),
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .RsD           (RsD),
    .RtD           (RtD),
    .RsE           (RsE),
    .RtE           (RtE),
    .WriteRegE     (WriteRegE),
    .WriteRegM     (WriteRegM),
    .WriteRegW     (WriteRegW),
    .BranchD       (BranchD),
    .MfhiloD       (MfhiloD),
    .StartMDD      (StartMDD),
    .RegWriteE     (RegWriteE),
    .RegWriteM     (RegWriteM),
    .RegWriteW     (RegWriteW),
    .MemtoRegE     (MemtoRegE),
    .MemtoRegM     (MemtoRegM),
    .MemAccessM    (MemAccessM),
    .StartMDE      (StartMDE),
    .CntClear      (CntClear),
    .StallF        (StallF),
    .StallD        (StallD),
    .StallE        (StallE),
    .StallM        (StallM),
    .FlushE        (FlushE),
    .FlushW        (FlushW),
    .ForwardAE     (ForwardAE),
    .ForwardBE     (ForwardBE),
    .ForwardAD     (ForwardAD),
    .ForwardBD     (ForwardBD),
    .MdBusy        (MdBusy),
    .LoadStallCnt  (LoadStallCnt),
    .BranchStallCnt(BranchStallCnt),
    .MemStallCnt   (MemStallCnt),
    .MdStallCnt    (MdStallCnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    if (obs !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model state: cycles the current memory access still occupies M after this one,
  // remaining mult/div busy cycles, and the four stall tallies.
  int m_hold, md_left, c_load, c_br, c_mem, c_md;
  bit e_lw, e_br, e_mw, e_mds;

  function automatic int fwd_e(input int r);
    if (r != 0 && r == int'(WriteRegM) && RegWriteM) return 2;
    if (r != 0 && r == int'(WriteRegW) && RegWriteW) return 1;
    return 0;
  endfunction

  function automatic bit dst_hit(input int d);
    return d != 0 && (d == int'(RsD) || d == int'(RtD));
  endfunction

  function automatic int sat_inc(input int v);
    return (v < CNT_MAX) ? v + 1 : CNT_MAX;
  endfunction

  task automatic model_clear();
    m_hold = 0; md_left = 0;
    c_load = 0; c_br = 0; c_mem = 0; c_md = 0;
  endtask

  // Compute expected outputs from current inputs and model state, and compare all of them
  task automatic model_and_check();
    bit stl, flE;
    if (reset) model_clear();
    e_lw  = MemtoRegE && dst_hit(int'(WriteRegE));
    e_br  = BranchD && ((RegWriteE && dst_hit(int'(WriteRegE))) ||
                        (MemtoRegM && dst_hit(int'(WriteRegM))));
    e_mw  = (m_hold == 0) ? (MemAccessM && MEM_LAT > 1) : (m_hold > 1);
    e_mds = (md_left > 0 || StartMDE) && (MfhiloD || StartMDD);
    stl   = e_mw || e_lw || e_br || e_mds;
    flE   = (e_lw || e_br || e_mds) && !e_mw;
    check("ForwardAE", ForwardAE, fwd_e(int'(RsE)));
    check("ForwardBE", ForwardBE, fwd_e(int'(RtE)));
    check("ForwardAD", ForwardAD, int'(RsD != 0 && RsD == WriteRegM && RegWriteM));
    check("ForwardBD", ForwardBD, int'(RtD != 0 && RtD == WriteRegM && RegWriteM));
    check("StallF", StallF, int'(stl));
    check("StallD", StallD, int'(stl));
    check("StallE", StallE, int'(e_mw));
    check("StallM", StallM, int'(e_mw));
    check("FlushW", FlushW, int'(e_mw));
    check("FlushE", FlushE, int'(flE));
    check("MdBusy", MdBusy, int'(md_left > 0));
    check("LoadStallCnt", LoadStallCnt, c_load);
    check("BranchStallCnt", BranchStallCnt, c_br);
    check("MemStallCnt", MemStallCnt, c_mem);
    check("MdStallCnt", MdStallCnt, c_md);
  endtask

  // Advance the model across a rising edge
  task automatic model_seq();
    if (reset) begin
      model_clear();
      return;
    end
    if (CntClear) begin
      c_load = 0; c_br = 0; c_mem = 0; c_md = 0;
    end else begin
      if (e_lw && !e_mw)  c_load = sat_inc(c_load);
      if (e_br && !e_mw)  c_br   = sat_inc(c_br);
      if (e_mw)           c_mem  = sat_inc(c_mem);
      if (e_mds && !e_mw) c_md   = sat_inc(c_md);
    end
    if (m_hold == 0) begin
      if (MemAccessM && MEM_LAT > 1) m_hold = MEM_LAT - 1;
    end else begin
      m_hold = m_hold - 1;
    end
    if (StartMDE && !e_mw) md_left = MD_LAT;
    else if (md_left > 0)  md_left = md_left - 1;
  endtask

  // One clock: check mid-cycle, advance on the edge, return just after it
  task automatic cycle();
    @(negedge clk);
    model_and_check();
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic clear_inputs();
    RsD = '0; RtD = '0; RsE = '0; RtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    BranchD = 0; MfhiloD = 0; StartMDD = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0; MemAccessM = 0;
    StartMDE = 0; CntClear = 0;
  endtask

  task automatic drive_random();
    RsD = REG_AW'($urandom_range(0, 3));
    RtD = REG_AW'($urandom_range(0, 3));
    RsE = REG_AW'($urandom_range(0, 3));
    RtE = REG_AW'($urandom_range(0, 3));
    WriteRegE = REG_AW'($urandom_range(0, 3));
    WriteRegM = REG_AW'($urandom_range(0, 3));
    WriteRegW = REG_AW'($urandom_range(0, 3));
    BranchD    = ($urandom_range(0, 3) == 0);
    MfhiloD    = ($urandom_range(0, 5) == 0);
    StartMDD   = ($urandom_range(0, 7) == 0);
    RegWriteE  = $urandom_range(0, 1) == 1;
    RegWriteM  = $urandom_range(0, 1) == 1;
    RegWriteW  = $urandom_range(0, 1) == 1;
    MemtoRegE  = ($urandom_range(0, 3) == 0);
    MemtoRegM  = ($urandom_range(0, 3) == 0);
    MemAccessM = ($urandom_range(0, 4) == 0);
    StartMDE   = ($urandom_range(0, 7) == 0);
    CntClear   = ($urandom_range(0, 59) == 0);
    reset      = ($urandom_range(0, 119) == 0);
  endtask

  initial begin
    int highs;
    model_clear();
    e_lw = 0; e_br = 0; e_mw = 0; e_mds = 0;
    clear_inputs();
    reset = 1'b1;
    #2;
    check("rst_StallF", StallF, 0);
    check("rst_MdBusy", MdBusy, 0);
    cycle();
    cycle();
    reset = 1'b0;

    // Forwarding priority and register-zero exclusion
    RsE = 5; WriteRegM = 5; RegWriteM = 1; WriteRegW = 5; RegWriteW = 1;
    #1 check("fwdAE_m", ForwardAE, 2);
    cycle();
    RsE = 0;
    #1 check("fwdAE_r0", ForwardAE, 0);
    cycle();
    RtE = 5; RegWriteM = 0;
    #1 check("fwdBE_w", ForwardBE, 1);
    cycle();
    clear_inputs();

    // Load-use: one stall cycle
    MemtoRegE = 1; WriteRegE = 8; RtD = 8;
    #1 check("lw_FlushE", FlushE, 1);
    cycle();
    clear_inputs();
    cycle();
    check("lw_cnt", LoadStallCnt, 1);

    // Multi-cycle memory with a load-use hazard present: E frozen, not flushed
    MemAccessM = 1; MemtoRegE = 1; WriteRegE = 8; RtD = 8;
    #1 check("mw_FlushE", FlushE, 0);
    check("mw_StallM", StallM, 1);
    highs = 0;
    for (int i = 0; i < 3; i++) begin
      #1 highs += int'(FlushW);
      cycle();
    end
    check("mw_cycles", highs, MEM_LAT - 1);
    check("mw_cnt", MemStallCnt, MEM_LAT - 1);
    clear_inputs();
    CntClear = 1;
    cycle();
    clear_inputs();

    // Mult/div then HI/LO read held in D
    StartMDE = 1; MfhiloD = 1;
    highs = 0;
    for (int i = 0; i < MD_LAT + 3; i++) begin
      #1 highs += int'(StallD);
      cycle();
      StartMDE = 0;
    end
    check("md_stall_cycles", highs, MD_LAT + 1);
    check("md_cnt", MdStallCnt, MD_LAT + 1);
    clear_inputs();

    // Start held during memwait is not accepted until M moves
    MemAccessM = 1; StartMDE = 1;
    cycle();
    check("md_in_mw1", MdBusy, 0);
    cycle();
    check("md_in_mw2", MdBusy, 0);
    cycle();
    check("md_after_mw", MdBusy, 1);
    clear_inputs();
    for (int i = 0; i < MD_LAT + 1; i++) cycle();

    // Async reset while waiting on memory with a multiply in flight
    StartMDE = 1;
    cycle();
    clear_inputs();
    cycle();
    MemAccessM = 1;
    cycle();
    clear_inputs();
    #2 reset = 1'b1;
    #1 check("arst_mem_cnt", MemStallCnt, 0);
    check("arst_md_cnt", MdStallCnt, 0);
    check("arst_busy", MdBusy, 0);
    check("arst_StallM", StallM, 0);
    model_clear();
    cycle();
    reset = 1'b0;

    // Saturation and clear priority
    MemtoRegE = 1; WriteRegE = 8; RtD = 8;
    for (int i = 0; i < CNT_MAX + 5; i++) cycle();
    check("sat_load", LoadStallCnt, CNT_MAX);
    CntClear = 1;
    cycle();
    check("clr_prio", LoadStallCnt, 0);
    clear_inputs();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      drive_random();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
